trap_sequencer: RTL

Machine-mode trap/return sequencer for the RV32 core. It owns the single write port of the CSR register file. It arbitrates that port between pipeline CSR instructions and trap entry/exit, and it prioritises interrupt and exception sources. On a trap it performs the mepc/mcause/mtval/mstatus updates as a multi-cycle sequence, then issues a one-cycle PC redirect to the fetch stage.

---
 rtl/trap_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer owning the CSR write port; vectored irq entry under TRAP_VECTORED_EN.
// Latency: trap writes at T+1..T+4 and redirect at T+5; mret writes status at T+1 and redirects at T+2.
// Backpressure: stall is high from detect through REDIRECT; pipeline CSR writes pass only in IDLE with no detect.
module trap_sequencer #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MSTATUS_RST = 32'h88
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            irq,
    input  logic            illegal_inst,
    input  logic            l_access_fault,
    input  logic            s_access_fault,
    input  logic            ecall_m,
    input  logic            mret,
    input  logic [XLEN-1:0] inst_ill,
    input  logic [XLEN-1:0] addr_access_fault,
    input  logic [XLEN-1:0] epc_cur,
    input  logic [XLEN-1:0] epc_next,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            pipe_csr_we,
    input  logic [11:0]     pipe_csr_waddr,
    input  logic [XLEN-1:0] pipe_csr_wdata,
    input  logic [1:0]      pipe_csr_mode,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [1:0]      csr_mode,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [1:0]  MODE_WRITE   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STATUS, S_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d, tval_q, tval_d, epc_q, epc_d;
    logic            ret_q, ret_d, flush_q, flush_d;
    logic            irq_take, trap_det, detect;
    logic [XLEN-1:0] trap_cause, trap_tval, trap_epc;
    logic [XLEN-1:0] status_trap, status_ret, trap_target;
    logic            unused_ok;

    assign unused_ok = ^{MSTATUS_RST, mie_i[XLEN-1:12], mie_i[10:0], mtvec_i[1:0]};

    // Source priority: interrupt, illegal, load fault, store fault, ecall (mret handled below).
    always_comb begin
        irq_take   = irq & mstatus_i[3] & mie_i[11];
        trap_det   = 1'b1;
        trap_cause = '0;
        trap_tval  = '0;
        trap_epc   = epc_cur;
        if (irq_take) begin
            trap_cause = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
            trap_epc   = epc_next;
        end else if (illegal_inst) begin
            trap_cause = XLEN'(2);
            trap_tval  = inst_ill;
        end else if (l_access_fault) begin
            trap_cause = XLEN'(5);
            trap_tval  = addr_access_fault;
        end else if (s_access_fault) begin
            trap_cause = XLEN'(7);
            trap_tval  = addr_access_fault;
        end else if (ecall_m) begin
            trap_cause = XLEN'(11);
        end else begin
            trap_det = 1'b0;
        end
    end

    assign detect = (state_q == S_IDLE) & (trap_det | mret);

    always_comb begin
        status_trap        = mstatus_i;
        status_trap[12:11] = 2'b11;
        status_trap[7]     = mstatus_i[3];
        status_trap[3]     = 1'b0;
        status_ret         = mstatus_i;
        status_ret[12:11]  = 2'b11;
        status_ret[7]      = 1'b1;
        status_ret[3]      = mstatus_i[7];
    end

    always_comb begin
        trap_target = mtvec_i & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
        if (mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1])
            trap_target = (mtvec_i & ~XLEN'(3)) + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
`endif
    end

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        tval_d         = tval_q;
        epc_d          = epc_q;
        ret_d          = ret_q;
        flush_d        = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_mode       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = (state_q != S_IDLE) | detect;
        unique case (state_q)
            S_IDLE: begin
                if (detect) begin
                    flush_d = 1'b1;
                    ret_d   = ~trap_det;
                    state_d = trap_det ? S_W_EPC : S_W_STATUS;
                    if (trap_det) begin
                        cause_d = trap_cause;
                        tval_d  = trap_tval;
                        epc_d   = trap_epc;
                    end
                end else begin
                    csr_we    = pipe_csr_we;
                    csr_waddr = pipe_csr_waddr;
                    csr_wdata = pipe_csr_wdata;
                    csr_mode  = pipe_csr_mode;
                end
            end
            S_W_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = epc_q;
                csr_mode  = MODE_WRITE;
                state_d   = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = cause_q;
                csr_mode  = MODE_WRITE;
                state_d   = S_W_TVAL;
            end
            S_W_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MTVAL;
                csr_wdata = tval_q;
                csr_mode  = MODE_WRITE;
                state_d   = S_W_STATUS;
            end
            S_W_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = ret_q ? status_ret : status_trap;
                csr_mode  = MODE_WRITE;
                state_d   = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = ret_q ? mepc_i : trap_target;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            tval_q  <= '0;
            epc_q   <= '0;
            ret_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            epc_q   <= epc_d;
            ret_q   <= ret_d;
            flush_q <= flush_d;
        end
    end

    assign flush = flush_q;

endmodule
